mfp_pmod_als_spi_responder: RTL

//  SPI responder (slave) that emulates the Pmod ALS light-sensor ADC on the board-side SPI link.

---
 rtl/mfp_pmod_als_spi_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mfp_pmod_als_spi_responder.sv
// SPI responder emulating the Pmod ALS ADC. It shifts a FRAME_BITS word out MSB
// first on sdo, one bit per falling sck edge, after a single leading zero.
// cs and sck are asynchronous to clock, so both are oversampled through synchronizers.
// Edges are detected entirely in the clock domain.
module mfp_pmod_als_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  sck,
    output logic                  sdo,
    output logic                  sdo_oe,
    input  logic [FRAME_BITS-1:0] value,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [1:0]            state_dbg
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    // Synchronizer chains. Bit 0 is the first stage and the top bit is the synchronized value.
    // sck resets high, which is the idle level of the master's clock.
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sck_prev_q, sck_prev_d;

    logic cs_s, sck_s;
    logic cs_fall, cs_rise, sck_fall;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  sdo_q, sdo_d;
    logic                  sdo_oe_q, sdo_oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;

    // Advance the synchronizer chains and remember the previous synchronized values.
    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_prev_d  = cs_sync_q[SYNC_STAGES-1];
        sck_prev_d = sck_sync_q[SYNC_STAGES-1];
    end

    // Register the synchronizers and the edge-detect history.
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync_q  <= '0;
            sck_sync_q <= '1;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b1;
        end else begin
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            cs_prev_q  <= cs_prev_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign cs_fall = cs_prev_q & ~cs_s;
    assign cs_rise = ~cs_prev_q & cs_s;
    // sck activity only counts while the frame is selected.
    assign sck_fall = sck_prev_q & ~sck_s & ~cs_s;

    // Next-state and registered-output logic. cs rising takes priority over an sck fall in the same clock.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        count_d  = count_q;
        sdo_d    = sdo_q;
        sdo_oe_d = sdo_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            WAIT_HIGH: begin
                // A reset during a frame must not resume that frame, so wait for cs to be released first.
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d  = SHIFT;
                    shift_d  = value;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    count_d  = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    sdo_d    = 1'b0;
                    sdo_oe_d = 1'b0;
                    busy_d   = 1'b0;
                    if (count_q == CW'(FRAME_BITS)) begin
                        done_d = 1'b1;
                    end else begin
                        abort_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (count_q < CW'(FRAME_BITS)) begin
                        sdo_d   = shift_q[FRAME_BITS-1];
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        count_d = count_q + CW'(1);
                    end else begin
                        // Once the word is exhausted, any extra clocks from the master read back zero.
                        sdo_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = WAIT_HIGH;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= WAIT_HIGH;
            shift_q  <= '0;
            count_q  <= '0;
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            sdo_q    <= sdo_d;
            sdo_oe_q <= sdo_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    assign sdo         = sdo_q;
    assign sdo_oe      = sdo_oe_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign state_dbg   = state_q;

endmodule
